// File: rtl/stream_extreme_tracker_if.sv
// Sample-in / result-out handshake bundle for stream_extreme_tracker.
// The master is the sample source and result consumer; the slave is the tracker.
interface stream_extreme_tracker_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
);
  logic             mode;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_all_equal;
  logic             busy;

  modport master (
    output mode, clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_all_equal, busy
  );

  modport slave (
    input  mode, clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_all_equal, busy
  );
endinterface

// File: rtl/stream_extreme_tracker.sv
// Per-frame max/min tracker: reports the extreme value, its earliest index and
// an all-equal flag for every FRAME_LEN accepted samples, then holds until taken.
module stream_extreme_tracker #(
  parameter int WIDTH             = 4,
  parameter int FRAME_LEN         = 8,
  parameter int IDX_W             = 3,
  parameter int ZERO_ON_ALL_EQUAL = 1
) (
  input logic                   clk,
  input logic                   reset,
  stream_extreme_tracker_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(FRAME_LEN - 1);
  localparam bit               MULTI = (FRAME_LEN > 1);
  localparam bit               ZERO  = (ZERO_ON_ALL_EQUAL != 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             eq_q, eq_d;
  logic             mode_l_q, mode_l_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_eq_q, out_eq_d;

  // Running values including the sample on the input this cycle
  logic             in_xfer, out_xfer, better, fin_eq;
  logic [WIDTH-1:0] nb, nfirst;
  logic [IDX_W-1:0] nidx;
  logic             neq, nmode;

  always_comb begin
    in_xfer  = bus.in_valid && in_ready_q;
    out_xfer = out_valid_q && bus.out_ready;
    better   = mode_l_q ? (bus.in_data < best_q) : (bus.in_data > best_q);

    if (count_q == '0) begin
      nb     = bus.in_data;
      nfirst = bus.in_data;
      nidx   = '0;
      neq    = 1'b1;
      nmode  = bus.mode;
    end else begin
      nb     = better ? bus.in_data : best_q;
      nfirst = first_q;
      nidx   = better ? count_q : best_idx_q;
      neq    = eq_q && (bus.in_data == first_q);
      nmode  = mode_l_q;
    end
    fin_eq = MULTI && neq;

    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    first_d     = first_q;
    best_idx_d  = best_idx_q;
    eq_d        = eq_q;
    mode_l_d    = mode_l_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_eq_d    = out_eq_q;

    case (state_q)
      ACCUM: begin
        // clear wins over a sample offered in the same cycle
        if (bus.clear) begin
          count_d = '0;
        end else if (in_xfer) begin
          best_d     = nb;
          first_d    = nfirst;
          best_idx_d = nidx;
          eq_d       = neq;
          mode_l_d   = nmode;
          if (count_q == LAST) begin
            state_d     = HOLD;
            count_d     = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_idx_d   = nidx;
            out_eq_d    = fin_eq;
            out_data_d  = (fin_eq && ZERO) ? '0 : nb;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_xfer) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      best_q      <= '0;
      first_q     <= '0;
      best_idx_q  <= '0;
      eq_q        <= 1'b0;
      mode_l_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      first_q     <= first_d;
      best_idx_q  <= best_idx_d;
      eq_q        <= eq_d;
      mode_l_q    <= mode_l_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_eq_q    <= out_eq_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_idx       = out_idx_q;
  assign bus.out_all_equal = out_eq_q;
  assign bus.busy          = (count_q != '0) || (state_q == HOLD);
endmodule

// File: tb/tb_stream_extreme_tracker.sv
// Drives three tracker builds (FRAME_LEN=4 zeroing, FRAME_LEN=4 non-zeroing,
// FRAME_LEN=1) with shared stimulus and compares each against a queue-based model.
module tb_stream_extreme_tracker;
  localparam int N = 3;
  localparam int FLS [N] = '{4, 4, 1};
  localparam int ZS  [N] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       t_mode, t_clear, t_iv, t_ordy;
  logic [3:0] t_data;

  always #5 clk = ~clk;

  stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(2)) if0 ();
  stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(2)) if1 ();
  stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(1)) if2 ();

  assign if0.mode = t_mode;  assign if0.clear = t_clear;  assign if0.in_valid = t_iv;
  assign if0.in_data = t_data;  assign if0.out_ready = t_ordy;
  assign if1.mode = t_mode;  assign if1.clear = t_clear;  assign if1.in_valid = t_iv;
  assign if1.in_data = t_data;  assign if1.out_ready = t_ordy;
  assign if2.mode = t_mode;  assign if2.clear = t_clear;  assign if2.in_valid = t_iv;
  assign if2.in_data = t_data;  assign if2.out_ready = t_ordy;

  stream_extreme_tracker #(.WIDTH(4), .FRAME_LEN(4), .IDX_W(2), .ZERO_ON_ALL_EQUAL(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  stream_extreme_tracker #(.WIDTH(4), .FRAME_LEN(4), .IDX_W(2), .ZERO_ON_ALL_EQUAL(0))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  stream_extreme_tracker #(.WIDTH(4), .FRAME_LEN(1), .IDX_W(1), .ZERO_ON_ALL_EQUAL(1))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [31:0] o_valid [N], o_ready [N], o_busy [N], o_data [N], o_idx [N], o_eq [N];
  assign o_valid[0] = 32'(if0.out_valid);  assign o_ready[0] = 32'(if0.in_ready);
  assign o_busy[0]  = 32'(if0.busy);       assign o_data[0]  = 32'(if0.out_data);
  assign o_idx[0]   = 32'(if0.out_idx);    assign o_eq[0]    = 32'(if0.out_all_equal);
  assign o_valid[1] = 32'(if1.out_valid);  assign o_ready[1] = 32'(if1.in_ready);
  assign o_busy[1]  = 32'(if1.busy);       assign o_data[1]  = 32'(if1.out_data);
  assign o_idx[1]   = 32'(if1.out_idx);    assign o_eq[1]    = 32'(if1.out_all_equal);
  assign o_valid[2] = 32'(if2.out_valid);  assign o_ready[2] = 32'(if2.in_ready);
  assign o_busy[2]  = 32'(if2.busy);       assign o_data[2]  = 32'(if2.out_data);
  assign o_idx[2]   = 32'(if2.out_idx);    assign o_eq[2]    = 32'(if2.out_all_equal);

  // Model: a frame is the list of accepted samples; the result is computed when it fills
  int unsigned m_q     [N][$];
  bit          m_hold  [N];
  bit          m_mode  [N];
  int unsigned m_valid [N], m_data [N], m_idx [N], m_eq [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step_model(input int k);
    int unsigned bi;
    bit          alleq;
    if (reset) begin
      m_q[k].delete();
      m_hold[k] = 1'b0; m_mode[k] = 1'b0;
      m_valid[k] = 0; m_data[k] = 0; m_idx[k] = 0; m_eq[k] = 0;
    end else if (m_hold[k]) begin
      if (t_ordy) begin
        m_hold[k]  = 1'b0;
        m_valid[k] = 0;
      end
    end else if (t_clear) begin
      m_q[k].delete();
    end else if (t_iv) begin
      if (m_q[k].size() == 0) m_mode[k] = t_mode;
      m_q[k].push_back(32'(t_data));
      if (m_q[k].size() == FLS[k]) begin
        bi = 0;
        alleq = 1'b1;
        for (int i = 0; i < FLS[k]; i++) begin
          if (m_mode[k] ? (m_q[k][i] < m_q[k][bi]) : (m_q[k][i] > m_q[k][bi])) bi = i;
          if (m_q[k][i] != m_q[k][0]) alleq = 1'b0;
        end
        m_eq[k]    = (alleq && FLS[k] > 1) ? 1 : 0;
        m_idx[k]   = bi;
        m_data[k]  = (m_eq[k] != 0 && ZS[k] != 0) ? 0 : m_q[k][bi];
        m_valid[k] = 1;
        m_hold[k]  = 1'b1;
        m_q[k].delete();
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("d%0d.out_valid", k), o_valid[k], m_valid[k]);
      chk($sformatf("d%0d.in_ready", k), o_ready[k], m_hold[k] ? 0 : 1);
      chk($sformatf("d%0d.busy", k), o_busy[k], (m_hold[k] || m_q[k].size() != 0) ? 1 : 0);
      chk($sformatf("d%0d.out_data", k), o_data[k], m_data[k]);
      chk($sformatf("d%0d.out_idx", k), o_idx[k], m_idx[k]);
      chk($sformatf("d%0d.out_all_equal", k), o_eq[k], m_eq[k]);
    end
  endtask

  // One clock: drive at the falling edge, predict, then compare at the next falling edge
  task automatic cyc(input bit r, input bit m, input bit c, input bit iv,
                     input logic [3:0] d, input bit ordy);
    reset = r; t_mode = m; t_clear = c; t_iv = iv; t_data = d; t_ordy = ordy;
    for (int k = 0; k < N; k++) step_model(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input bit m, input logic [3:0] d);
    cyc(1'b0, m, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic release_out();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; t_mode = 1'b0; t_clear = 1'b0; t_iv = 1'b0; t_data = '0; t_ordy = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_valid", o_valid[0], 0);
    chk("rst_ready", o_ready[0], 1);
    chk("rst_busy", o_busy[0], 0);

    // max frame, then stall the consumer while offering extra samples
    send(0, 3); send(0, 9); send(0, 2); send(0, 7);
    chk("max_valid", o_valid[0], 1);
    chk("max_data", o_data[0], 9);
    chk("max_idx", o_idx[0], 1);
    chk("max_eq", o_eq[0], 0);
    chk("max_ready", o_ready[0], 0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    chk("hold_data", o_data[0], 9);
    chk("hold_busy", o_busy[0], 1);
    release_out();
    chk("rel_valid", o_valid[0], 0);
    chk("rel_data_kept", o_data[0], 9);

    // min frame with earliest-tie rule; mode toggled after the first sample
    send(1, 5); send(0, 1); send(0, 8); send(0, 1);
    chk("min_data", o_data[0], 1);
    chk("min_idx", o_idx[0], 1);
    release_out();

    // all-equal frame in both zeroing builds
    send(0, 6); send(0, 6); send(0, 6); send(0, 6);
    chk("eq_flag", o_eq[0], 1);
    chk("eq_zero_data", o_data[0], 0);
    chk("eq_zero_idx", o_idx[0], 0);
    chk("eq_keep_data", o_data[1], 6);
    release_out();

    // single-sample frames
    send(0, 5);
    chk("fl1_valid", o_valid[2], 1);
    chk("fl1_data", o_data[2], 5);
    chk("fl1_idx", o_idx[2], 0);
    chk("fl1_eq", o_eq[2], 0);
    send(0, 5); send(0, 5); send(0, 5);
    release_out();

    // clear drops the partial frame and the concurrent sample
    send(0, 4); send(0, 12);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    send(0, 1); send(0, 2); send(0, 3); send(0, 0);
    chk("clr_data", o_data[0], 3);
    chk("clr_idx", o_idx[0], 2);
    release_out();

    // reset mid-frame and during HOLD
    send(0, 7); send(0, 8); send(0, 9);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
    chk("rst_mid_busy", o_busy[0], 0);
    chk("rst_mid_data", o_data[0], 0);
    send(0, 2); send(0, 11); send(0, 4); send(0, 1);
    chk("pre_rst_hold_valid", o_valid[0], 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_hold_valid", o_valid[0], 0);
    chk("rst_hold_data", o_data[0], 0);
    chk("rst_hold_idx", o_idx[0], 0);
    chk("rst_hold_ready", o_ready[0], 1);

    // randomized traffic; narrow value range half the time to provoke ties
    repeat (3000) begin
      cyc($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15)),
          $urandom_range(0, 1) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_extreme_tracker.md
Name: stream_extreme_tracker

Overview:
Parametrised successor to the team's 4-bit two-input max comparator. Accepts a stream of unsigned WIDTH-bit samples over a valid/ready handshake. Finds the maximum or minimum of each FRAME_LEN-sample frame and reports the winning value, its index and an all-equal flag over an output handshake. Sits between a sample source (switch/ADC capture logic) and display/decision logic.

Parameters:
WIDTH, 4, sample width in bits, 1..32
FRAME_LEN, 8, samples per frame, >=1
IDX_W, 3, index width; must satisfy 2^IDX_W >= FRAME_LEN, minimum 1
ZERO_ON_ALL_EQUAL, 1, 1: all-equal frame reports out_data=0 (legacy comparator rule); 0: reports the common value

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
mode  in  1  0=max, 1=min; latched on the first accepted sample of a frame
clear  in  1  abort the partial frame (ACCUM only)
in_valid  in  1  sample offered
in_data  in  WIDTH  sample value, unsigned
in_ready  out  1  block can accept a sample
out_valid  out  1  frame result available
out_ready  in  1  consumer accepts the result
out_data  out  WIDTH  extreme value, or 0 per ZERO_ON_ALL_EQUAL
out_idx  out  IDX_W  0-based frame position of the extreme
out_all_equal  out  1  every sample in the frame was equal (forced 0 when FRAME_LEN==1)
busy  out  1  high when count!=0 or state==HOLD

Behaviour:
- One clock, synchronous active-high reset on clk; reset has priority over all other inputs.
- Reset values: state=ACCUM, count=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_all_equal=0, busy=0, internal best/first/mode registers=0.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- State ACCUM:
  - in_ready=1.
  - On a transfer with count==0: best=in_data, first=in_data, best_idx=0, eq=1, mode_l=mode.
  - On a transfer with count>0:
    - mode_l=0: replace best/best_idx if in_data > best.
    - mode_l=1: replace if in_data < best.
    - Ties keep the earliest index.
    - eq cleared if in_data != first.
    - count increments.
  - mode changes mid-frame are ignored.
  - Comparisons are unsigned and full WIDTH; no arithmetic widening needed.
  - On the transfer that completes the frame (count==FRAME_LEN-1, or any transfer when FRAME_LEN==1), the next cycle shows:
    - state=HOLD, out_valid=1, count=0
    - out_idx = final best index
    - out_all_equal = final eq (0 if FRAME_LEN==1)
    - out_data = 0 if (out_all_equal && ZERO_ON_ALL_EQUAL), else final best
  - Latency: 1 cycle from the last accepted sample to out_valid.
  - clear in ACCUM: count->0 next cycle. A sample offered in the same cycle is dropped, because clear has priority over in_valid. Outputs are unchanged.
- State HOLD:
  - in_ready=0. out_valid stays 1 and out_data, out_idx, out_all_equal stay stable until an output transfer.
  - clear and in_valid are ignored.
  - On an output transfer: next cycle state=ACCUM, out_valid=0. out_data, out_idx, out_all_equal keep their last values.
  - No sample is accepted in the handshake cycle itself; minimum frame-to-frame gap is 1 cycle.
- Back-to-back input with in_valid held high: one sample per cycle in ACCUM.
- Reset asserted mid-frame or during HOLD: partial frame or pending result is discarded; reset values apply next cycle.

Test Plan:
- WIDTH=4, FRAME_LEN=4, mode=0, samples 3,9,2,7 -> one cycle after the 4th sample: out_valid=1, out_data=9, out_idx=1, out_all_equal=0; in_ready=0 until out_ready.
- mode=1, samples 5,1,8,1 -> out_data=1, out_idx=1 (earliest tie); toggling mode to 0 after the first sample has no effect.
- Samples 6,6,6,6 -> out_all_equal=1. ZERO_ON_ALL_EQUAL=1 gives out_data=0, out_idx=0; a second build with ZERO_ON_ALL_EQUAL=0 gives out_data=6.
- Frame complete, hold out_ready=0 for 5 cycles while driving in_valid with 15 -> outputs stable, in_ready=0, sample not counted. Raise out_ready -> out_valid=0 next cycle, then a new frame starts.
- Accept 2 samples (4,12), pulse clear with in_valid and in_data=15, then send 1,2,3,0 -> out_data=3, out_idx=2. Neither 12 nor 15 appears.
- Reset asserted after 3 samples and again during HOLD -> all outputs return to reset values next cycle. FRAME_LEN=1 build: every sample yields a result with out_idx=0 and out_all_equal=0.
